// File: rtl/dut_or_pkg.sv
// Shared definitions for the OR-gate DUT bus sequencer: the DUT register map,
// the sequencer state encoding and the per-state bus operation decode.
package dut_or_pkg;

  // DUT register map
  localparam logic [2:0] A_STATUS = 3'd0;  // 1 = A FIFO not full
  localparam logic [2:0] B_STATUS = 3'd1;  // 1 = B FIFO not full
  localparam logic [2:0] Y_STATUS = 3'd2;  // 1 = Y FIFO not empty
  localparam logic [2:0] Y_OUTPUT = 3'd3;
  localparam logic [2:0] A_DATA   = 3'd4;
  localparam logic [2:0] B_DATA   = 3'd5;

  typedef enum logic [2:0] {
    IDLE, POLL_A, WR_A, POLL_B, WR_B, POLL_Y, RD_Y, RSP
  } state_t;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [2:0] addr;
  } bus_op_t;

  // Bus access each state presents; IDLE and RSP leave the bus quiet.
  function automatic bus_op_t bus_op(state_t s);
    bus_op_t op;
    op = '0;
    case (s)
      POLL_A:  op = '{rd: 1'b1, wr: 1'b0, addr: A_STATUS};
      WR_A:    op = '{rd: 1'b0, wr: 1'b1, addr: A_DATA};
      POLL_B:  op = '{rd: 1'b1, wr: 1'b0, addr: B_STATUS};
      WR_B:    op = '{rd: 1'b0, wr: 1'b1, addr: B_DATA};
      POLL_Y:  op = '{rd: 1'b1, wr: 1'b0, addr: Y_STATUS};
      RD_Y:    op = '{rd: 1'b1, wr: 1'b0, addr: Y_OUTPUT};
      default: op = '0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/dut_or_sequencer_if.sv
// Client request/response handshake plus the DUT register bus, bundled so the
// sequencer (master) and its environment (slave) connect through one port.
interface dut_or_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_a;
  logic       req_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_y;
  logic       rsp_err;
  logic [2:0] write_address;
  logic       write_data;
  logic       write_en;
  logic       write_rdy;
  logic [2:0] read_address;
  logic       read_en;
  logic       read_data;
  logic       read_rdy;

  modport master (
    input  req_valid, req_a, req_b, rsp_ready, write_rdy, read_data, read_rdy,
    output req_ready, rsp_valid, rsp_y, rsp_err,
           write_address, write_data, write_en, read_address, read_en
  );

  modport slave (
    output req_valid, req_a, req_b, rsp_ready, write_rdy, read_data, read_rdy,
    input  req_ready, rsp_valid, rsp_y, rsp_err,
           write_address, write_data, write_en, read_address, read_en
  );
endinterface

// File: rtl/dut_or_sequencer_stall_timer.sv
// Saturating stall counter: cleared on forward progress, counts stalled cycles,
// flags when the abort limit is reached.
module stall_timer #(
  parameter int LIMIT = 255,
  parameter int TW    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic term
);

  localparam logic [TW-1:0] LIMIT_V = TW'(LIMIT);

  logic [TW-1:0] count;

  // Count stalled cycles, holding at the limit instead of wrapping.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create order races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        count <= '0;
    else if (clr)                      count <= '0;
    else if (inc && count != LIMIT_V)  count <= count + TW'(1);
  end

  assign term = (count == LIMIT_V);

endmodule

// File: rtl/dut_or_sequencer.sv
// Bus-master sequencer for the 1-bit OR-gate DUT: accepts an (a, b) pair, runs
// poll/write/poll/write/poll/read on the DUT register bus and returns y, with a
// stall timeout that aborts to the response state with rsp_err set.
module dut_or_sequencer
  import dut_or_pkg::*;
#(
  parameter int POLL_LIMIT = 255,
  parameter int TW         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  dut_or_sequencer_if.master bus
);

  state_t  state, state_n;
  bus_op_t op;
  logic    a_q, b_q;
  logic    y_q, err_q;
  logic    rd_fire, wr_fire;
  logic    abort;
  logic    tmr_clr, tmr_inc, tmr_term;

  // Moore bus outputs: everything decodes from the state register.
  assign op      = bus_op(state);
  assign rd_fire = op.rd && bus.read_rdy;
  assign wr_fire = op.wr && bus.write_rdy;

  assign bus.read_en       = op.rd;
  assign bus.read_address  = op.rd ? op.addr : 3'd0;
  assign bus.write_en      = op.wr;
  assign bus.write_address = op.wr ? op.addr : 3'd0;
  assign bus.write_data    = (state == WR_A) ? a_q :
                             (state == WR_B) ? b_q : 1'b0;
  assign bus.req_ready     = (state == IDLE);
  assign bus.rsp_valid     = (state == RSP);
  assign bus.rsp_y         = y_q;
  assign bus.rsp_err       = err_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state decode; a stall at the limit aborts to RSP unless the bus
  // makes progress in that very cycle.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    abort   = 1'b0;
    case (state)
      IDLE:    if (bus.req_valid)              state_n = POLL_A;
      POLL_A:  if (rd_fire && bus.read_data)   state_n = WR_A;
      WR_A:    if (wr_fire)                    state_n = POLL_B;
      POLL_B:  if (rd_fire && bus.read_data)   state_n = WR_B;
      WR_B:    if (wr_fire)                    state_n = POLL_Y;
      POLL_Y:  if (rd_fire && bus.read_data)   state_n = RD_Y;
      RD_Y:    if (rd_fire)                    state_n = RSP;
      RSP:     if (bus.rsp_ready)              state_n = IDLE;
      default:                                 state_n = IDLE;
    endcase
    if ((op.rd || op.wr) && state_n == state && tmr_term) begin
      state_n = RSP;
      abort   = 1'b1;
    end
    tmr_clr = (state_n != state);
    tmr_inc = op.rd || op.wr;
  end

  // Operand capture at acceptance, result capture on the Y read or abort.
  // NOTE: operand and result flops are reset too, so write_data and rsp_y
  // come out of reset at 0 rather than X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= 1'b0;
      b_q   <= 1'b0;
      y_q   <= 1'b0;
      err_q <= 1'b0;
    end else if (state == IDLE && bus.req_valid) begin
      a_q   <= bus.req_a;
      b_q   <= bus.req_b;
      y_q   <= 1'b0;
      err_q <= 1'b0;
    end else if (state == RD_Y && rd_fire) begin
      y_q   <= bus.read_data;
    end else if (abort) begin
      y_q   <= 1'b0;
      err_q <= 1'b1;
    end
  end

  stall_timer #(.LIMIT(POLL_LIMIT), .TW(TW)) u_stall_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .inc   (tmr_inc),
    .term  (tmr_term)
  );

endmodule

// File: tb/tb_dut_or_sequencer.sv
// Directed bench for dut_or_sequencer: a behavioural OR-gate DUT model on the
// main instance, and a second instance with a short timeout and Y stuck empty.
module tb_dut_or_sequencer;
  import dut_or_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dut_or_sequencer_if ifc ();
  dut_or_sequencer_if ifc2 ();

  dut_or_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(ifc.master));
  dut_or_sequencer #(.POLL_LIMIT(8), .TW(4)) dut_to (.clk(clk), .rst_n(rst_n), .bus(ifc2.master));

  int errors = 0;
  int checks = 0;
  int rr_viol = 0;

  // Behavioural DUT for the main instance
  int   a_zero_polls = 0;
  logic wr_rdy_tb = 1'b1;
  logic dut_a = 1'b0, dut_b = 1'b0;
  int   bus_log[$];   // reads log their address, writes log 10+address

  assign ifc.write_rdy = wr_rdy_tb;
  assign ifc.read_rdy  = 1'b1;

  always_comb begin
    ifc.read_data = 1'b0;
    case (ifc.read_address)
      A_STATUS: ifc.read_data = (a_zero_polls == 0);
      B_STATUS: ifc.read_data = 1'b1;
      Y_STATUS: ifc.read_data = 1'b1;
      Y_OUTPUT: ifc.read_data = dut_a | dut_b;
      default:  ifc.read_data = 1'b0;
    endcase
  end

  always @(posedge clk) begin
    if (ifc.write_en && ifc.write_rdy) begin
      bus_log.push_back(10 + int'(ifc.write_address));
      if (ifc.write_address == A_DATA) dut_a <= ifc.write_data;
      if (ifc.write_address == B_DATA) dut_b <= ifc.write_data;
    end
    if (ifc.read_en && ifc.read_rdy) begin
      bus_log.push_back(int'(ifc.read_address));
      if (ifc.read_address == A_STATUS && a_zero_polls > 0) a_zero_polls <= a_zero_polls - 1;
    end
  end

  // Timeout instance: always ready, Y FIFO never fills
  assign ifc2.write_rdy = 1'b1;
  assign ifc2.read_rdy  = 1'b1;
  assign ifc2.read_data = (ifc2.read_address != Y_STATUS);

  task automatic send_req(input logic a, input logic b);
    ifc.req_a = a;
    ifc.req_b = b;
    ifc.req_valid = 1'b1;
  endtask

  task automatic wait_rsp(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      ifc.req_valid = 1'b0;
      if (!ifc.rsp_valid && ifc.req_ready) rr_viol++;
    end while (!ifc.rsp_valid && cyc < budget);
  endtask

  task automatic ack_rsp;
    ifc.rsp_ready = 1'b1;
    @(negedge clk);
    ifc.rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (ifc.req_ready !== 1'b1 || ifc.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hs: req_ready=%b rsp_valid=%b want 1 0", ifc.req_ready, ifc.rsp_valid);
    end
    checks++;
    if (ifc.rsp_y !== 1'b0 || ifc.rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_rsp: rsp_y=%b rsp_err=%b want 0 0", ifc.rsp_y, ifc.rsp_err);
    end
    checks++;
    if ({ifc.write_en, ifc.read_en, ifc.write_address, ifc.read_address, ifc.write_data} !== 9'b0) begin
      errors++; $display("FAIL reset_bus: we=%b re=%b wa=%0d ra=%0d wd=%b want all 0",
                         ifc.write_en, ifc.read_en, ifc.write_address, ifc.read_address, ifc.write_data);
    end
  endtask

  task automatic test_latency;
    int cyc;
    int exp_seq[6] = '{0, 14, 1, 15, 2, 3};
    bit seq_ok;
    bus_log.delete();
    send_req(1'b1, 1'b0);
    wait_rsp(50, cyc);
    checks++;
    if (!ifc.rsp_valid || cyc != 7) begin
      errors++; $display("FAIL latency: rsp_valid=%b at cycle %0d want 1 at 7", ifc.rsp_valid, cyc);
    end
    checks++;
    if (ifc.rsp_y !== 1'b1 || ifc.rsp_err !== 1'b0) begin
      errors++; $display("FAIL latency_rsp: y=%b err=%b want 1 0", ifc.rsp_y, ifc.rsp_err);
    end
    seq_ok = (bus_log.size() == 6);
    for (int i = 0; i < 6 && seq_ok; i++) if (bus_log[i] != exp_seq[i]) seq_ok = 0;
    checks++;
    if (!seq_ok) begin
      errors++; $display("FAIL bus_seq: got %p want reads/writes 0,14,1,15,2,3", bus_log);
    end
    ack_rsp();
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic exp_y[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    rr_viol = 0;
    for (int i = 0; i < 4; i++) begin
      send_req(i[1], i[0]);
      wait_rsp(50, cyc);
      checks++;
      if (!ifc.rsp_valid || ifc.rsp_y !== exp_y[i] || ifc.rsp_err !== 1'b0) begin
        errors++; $display("FAIL b2b_%0d: valid=%b y=%b err=%b want 1 %b 0",
                           i, ifc.rsp_valid, ifc.rsp_y, ifc.rsp_err, exp_y[i]);
      end
      ack_rsp();
    end
    checks++;
    if (rr_viol != 0) begin
      errors++; $display("FAIL b2b_req_ready: high in %0d busy cycles want 0", rr_viol);
    end
  endtask

  task automatic test_a_poll;
    int cyc, polls;
    bus_log.delete();
    a_zero_polls = 3;
    send_req(1'b0, 1'b1);
    wait_rsp(60, cyc);
    polls = 0;
    foreach (bus_log[i]) begin
      if (bus_log[i] == 14) break;
      if (bus_log[i] == 0) polls++;
    end
    checks++;
    if (polls != 4) begin
      errors++; $display("FAIL a_poll_count: %0d reads of A_STATUS want 4", polls);
    end
    checks++;
    if (!ifc.rsp_valid || ifc.rsp_y !== 1'b1 || ifc.rsp_err !== 1'b0) begin
      errors++; $display("FAIL a_poll_rsp: valid=%b y=%b err=%b want 1 1 0", ifc.rsp_valid, ifc.rsp_y, ifc.rsp_err);
    end
    ack_rsp();
  endtask

  task automatic test_wr_stall;
    int cyc, wr_b;
    bit found, stable;
    bus_log.delete();
    send_req(1'b0, 1'b1);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      ifc.req_valid = 1'b0;
      if (ifc.write_en && ifc.write_address == B_DATA) begin
        wr_rdy_tb = 1'b0;
        found = 1;
      end
    end
    stable = found;
    repeat (10) begin
      @(negedge clk);
      if (!(ifc.write_en === 1'b1 && ifc.write_address === B_DATA && ifc.write_data === 1'b1 &&
            ifc.read_en === 1'b0)) stable = 0;
    end
    checks++;
    if (!stable) begin
      errors++; $display("FAIL wr_stall_hold: found=%b we=%b wa=%0d wd=%b want WR_B held with 1 5 1",
                         found, ifc.write_en, ifc.write_address, ifc.write_data);
    end
    wr_rdy_tb = 1'b1;
    wait_rsp(50, cyc);
    wr_b = 0;
    foreach (bus_log[i]) if (bus_log[i] == 15) wr_b++;
    checks++;
    if (wr_b != 1 || !ifc.rsp_valid || ifc.rsp_y !== 1'b1) begin
      errors++; $display("FAIL wr_stall_fire: B writes=%0d valid=%b y=%b want 1 1 1", wr_b, ifc.rsp_valid, ifc.rsp_y);
    end
    ack_rsp();
  endtask

  task automatic test_timeout;
    int cyc;
    logic prev_rd;
    ifc2.req_a = 1'b1;
    ifc2.req_b = 1'b1;
    ifc2.req_valid = 1'b1;
    cyc = 0;
    prev_rd = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      ifc2.req_valid = 1'b0;
      if (!ifc2.rsp_valid) prev_rd = ifc2.read_en;
    end while (!ifc2.rsp_valid && cyc < 100);
    checks++;
    if (!ifc2.rsp_valid || cyc != 14) begin
      errors++; $display("FAIL timeout_latency: valid=%b at cycle %0d want 1 at 14", ifc2.rsp_valid, cyc);
    end
    checks++;
    if (ifc2.rsp_err !== 1'b1 || ifc2.rsp_y !== 1'b0) begin
      errors++; $display("FAIL timeout_rsp: err=%b y=%b want 1 0", ifc2.rsp_err, ifc2.rsp_y);
    end
    checks++;
    if (ifc2.read_en !== 1'b0 || prev_rd !== 1'b1) begin
      errors++; $display("FAIL timeout_en_drop: read_en=%b before=%b want 0 after 1", ifc2.read_en, prev_rd);
    end
    ifc2.rsp_ready = 1'b1;
    @(negedge clk);
    ifc2.rsp_ready = 1'b0;
    ifc2.req_valid = 1'b1;
    @(negedge clk);
    ifc2.req_valid = 1'b0;
    checks++;
    if (ifc2.rsp_err !== 1'b0 || ifc2.req_ready !== 1'b0) begin
      errors++; $display("FAIL timeout_err_clear: err=%b req_ready=%b want 0 0", ifc2.rsp_err, ifc2.req_ready);
    end
    cyc = 0;
    while (!ifc2.rsp_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    ifc2.rsp_ready = 1'b1;
    @(negedge clk);
    ifc2.rsp_ready = 1'b0;
  endtask

  task automatic test_rsp_hold_and_reset;
    int cyc;
    bit held, found;
    send_req(1'b1, 1'b1);
    wait_rsp(50, cyc);
    held = ifc.rsp_valid;
    repeat (5) begin
      @(negedge clk);
      if (ifc.rsp_valid !== 1'b1) held = 0;
    end
    checks++;
    if (!held || ifc.rsp_y !== 1'b1) begin
      errors++; $display("FAIL rsp_hold: valid held=%b y=%b want 1 1", held, ifc.rsp_y);
    end
    ack_rsp();
    checks++;
    if (ifc.rsp_valid !== 1'b0 || ifc.req_ready !== 1'b1) begin
      errors++; $display("FAIL rsp_release: valid=%b req_ready=%b want 0 1", ifc.rsp_valid, ifc.req_ready);
    end
    wr_rdy_tb = 1'b0;
    send_req(1'b1, 1'b0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      ifc.req_valid = 1'b0;
      if (ifc.write_en && ifc.write_address == A_DATA && ifc.write_data) found = 1;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (!found || {ifc.write_en, ifc.read_en, ifc.write_address, ifc.read_address, ifc.write_data} !== 9'b0 ||
        ifc.req_ready !== 1'b1 || ifc.rsp_valid !== 1'b0 || ifc.rsp_err !== 1'b0 || ifc.rsp_y !== 1'b0) begin
      errors++; $display("FAIL async_reset: found=%b we=%b wa=%0d wd=%b rdy=%b valid=%b want WR_A then 0 0 0 1 0",
                         found, ifc.write_en, ifc.write_address, ifc.write_data, ifc.req_ready, ifc.rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wr_rdy_tb = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    ifc.req_valid = 1'b0;  ifc.req_a = 1'b0;  ifc.req_b = 1'b0;  ifc.rsp_ready = 1'b0;
    ifc2.req_valid = 1'b0; ifc2.req_a = 1'b0; ifc2.req_b = 1'b0; ifc2.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_latency();
    test_back_to_back();
    test_a_poll();
    test_wr_stall();
    test_timeout();
    test_rsp_hold_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
